// File: rtl/mem_arbiter.sv
// Two-requester (fetch / LSU) arbiter onto a single memory port.
// At most one bus transaction is outstanding; the LSU has priority, bounded by a fetch starvation limit.
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_flush,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        lsu_req,
  input  logic        lsu_we,
  input  logic [3:0]  lsu_be,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  output logic        lsu_gnt,
  output logic        lsu_rvalid,
  output logic        lsu_err,
  output logic [31:0] lsu_rdata,
  output logic        bus_req,
  output logic        bus_we,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic        bus_err,
  input  logic [31:0] bus_rdata,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, WAIT_GNT, WAIT_RSP} state_t;

  state_t      r_state, w_state_nxt;
  logic        r_owner_if, w_owner_if_nxt;
  logic        r_we, w_we_nxt;
  logic [3:0]  r_be, w_be_nxt;
  logic [31:0] r_addr, w_addr_nxt;
  logic [31:0] r_wdata, w_wdata_nxt;
  logic        r_discard, w_discard_nxt;
  logic [2:0]  r_starve, w_starve_nxt;

  logic        w_if_cand, w_sel_if, w_starved;
  logic        w_sel_we;
  logic [3:0]  w_sel_be;
  logic [31:0] w_sel_addr, w_sel_wdata;
  logic        w_cur_owner_if, w_bus_req, w_gnt;
  logic        w_bus_we;
  logic [3:0]  w_bus_be;
  logic [31:0] w_bus_addr, w_bus_wdata;
  logic        w_if_rv, w_if_er, w_lsu_rv, w_lsu_er;

  // A flushed fetch does not take part in arbitration that cycle.
  assign w_if_cand   = if_req & ~if_flush;
  assign w_starved   = (r_starve == 3'(STARVE_LIMIT));
  assign w_sel_if    = w_if_cand & (~lsu_req | w_starved);
  assign w_sel_we    = w_sel_if ? 1'b0     : lsu_we;
  assign w_sel_be    = w_sel_if ? 4'hF     : lsu_be;
  assign w_sel_addr  = w_sel_if ? if_addr  : lsu_addr;
  assign w_sel_wdata = w_sel_if ? '0       : lsu_wdata;

  always_comb begin
    w_state_nxt    = r_state;
    w_owner_if_nxt = r_owner_if;
    w_we_nxt       = r_we;
    w_be_nxt       = r_be;
    w_addr_nxt     = r_addr;
    w_wdata_nxt    = r_wdata;
    w_discard_nxt  = r_discard;
    w_starve_nxt   = r_starve;
    w_cur_owner_if = r_owner_if;
    w_bus_req      = 1'b0;
    w_bus_we       = r_we;
    w_bus_be       = r_be;
    w_bus_addr     = r_addr;
    w_bus_wdata    = r_wdata;
    w_if_rv        = 1'b0;
    w_if_er        = 1'b0;
    w_lsu_rv       = 1'b0;
    w_lsu_er       = 1'b0;
    case (r_state)
      IDLE: begin
        w_cur_owner_if = w_sel_if;
        w_bus_we       = w_sel_we;
        w_bus_be       = w_sel_be;
        w_bus_addr     = w_sel_addr;
        w_bus_wdata    = w_sel_wdata;
        if (w_if_cand || lsu_req) begin
          w_bus_req      = 1'b1;
          w_owner_if_nxt = w_sel_if;
          w_we_nxt       = w_sel_we;
          w_be_nxt       = w_sel_be;
          w_addr_nxt     = w_sel_addr;
          w_wdata_nxt    = w_sel_wdata;
          w_state_nxt    = bus_gnt ? WAIT_RSP : WAIT_GNT;
          if (!w_sel_if && if_req && !w_starved)
            w_starve_nxt = r_starve + 3'd1;
        end
      end
      WAIT_GNT: begin
        w_bus_req = 1'b1;
        if (bus_gnt)
          w_state_nxt = WAIT_RSP;
        if (r_owner_if && if_flush)
          w_discard_nxt = 1'b1;
      end
      WAIT_RSP: begin
        if (bus_rvalid) begin
          w_state_nxt   = IDLE;
          w_discard_nxt = 1'b0;
          if (r_owner_if) begin
            // A flush arriving with the response discards it just like an earlier one.
            if (!r_discard && !if_flush) begin
              w_if_rv = 1'b1;
              w_if_er = bus_err;
            end
          end else begin
            w_lsu_rv = 1'b1;
            w_lsu_er = bus_err;
          end
        end else if (r_owner_if && if_flush) begin
          w_discard_nxt = 1'b1;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
    w_gnt = w_bus_req & bus_gnt;
    if (w_gnt && w_cur_owner_if)
      w_starve_nxt = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_owner_if <= 1'b0;
      r_we       <= 1'b0;
      r_be       <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_discard  <= 1'b0;
      r_starve   <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_owner_if <= w_owner_if_nxt;
      r_we       <= w_we_nxt;
      r_be       <= w_be_nxt;
      r_addr     <= w_addr_nxt;
      r_wdata    <= w_wdata_nxt;
      r_discard  <= w_discard_nxt;
      r_starve   <= w_starve_nxt;
    end
  end

  // Combinational paths are masked during reset so nothing leaks while reset_n is low.
  assign bus_req    = reset_n & w_bus_req;
  assign bus_we     = reset_n & w_bus_req & w_bus_we;
  assign bus_be     = reset_n ? w_bus_be    : '0;
  assign bus_addr   = reset_n ? w_bus_addr  : '0;
  assign bus_wdata  = reset_n ? w_bus_wdata : '0;
  assign if_gnt     = reset_n & w_gnt & w_cur_owner_if;
  assign lsu_gnt    = reset_n & w_gnt & ~w_cur_owner_if;
  assign if_rvalid  = reset_n & w_if_rv;
  assign if_err     = reset_n & w_if_er;
  assign lsu_rvalid = reset_n & w_lsu_rv;
  assign lsu_err    = reset_n & w_lsu_er;
  assign if_rdata   = bus_rdata;
  assign lsu_rdata  = bus_rdata;
  assign busy       = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Scenario bench for mem_arbiter: expected responses are queued when the bus response is
// driven and compared against the requester outputs in the same cycle.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        if_req, if_flush;
  logic [31:0] if_addr;
  logic        if_gnt, if_rvalid, if_err;
  logic [31:0] if_rdata;
  logic        lsu_req, lsu_we;
  logic [3:0]  lsu_be;
  logic [31:0] lsu_addr, lsu_wdata;
  logic        lsu_gnt, lsu_rvalid, lsu_err;
  logic [31:0] lsu_rdata;
  logic        bus_req, bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_addr, bus_wdata;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_rdata;
  logic        busy;

  typedef struct packed {
    logic        if_v;
    logic        if_e;
    logic        lsu_v;
    logic        lsu_e;
    logic [31:0] data;
  } rsp_t;

  rsp_t sb[$];
  rsp_t exp_r, obs_r;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.STARVE_LIMIT(4)) dut (
    .clk(clk), .reset_n(reset_n),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_err(if_err), .if_rdata(if_rdata),
    .lsu_req(lsu_req), .lsu_we(lsu_we), .lsu_be(lsu_be), .lsu_addr(lsu_addr),
    .lsu_wdata(lsu_wdata), .lsu_gnt(lsu_gnt), .lsu_rvalid(lsu_rvalid),
    .lsu_err(lsu_err), .lsu_rdata(lsu_rdata),
    .bus_req(bus_req), .bus_we(bus_we), .bus_be(bus_be), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid),
    .bus_err(bus_err), .bus_rdata(bus_rdata), .busy(busy)
  );

  function automatic rsp_t observe();
    rsp_t r;
    r.if_v  = if_rvalid;
    r.if_e  = if_err;
    r.lsu_v = lsu_rvalid;
    r.lsu_e = lsu_err;
    r.data  = if_rdata;
    return r;
  endfunction

  function automatic rsp_t mk(input logic iv, input logic ie, input logic lv,
                              input logic le, input logic [31:0] d);
    rsp_t r;
    r.if_v = iv; r.if_e = ie; r.lsu_v = lv; r.lsu_e = le; r.data = d;
    return r;
  endfunction

  task automatic quiet();
    if_req = 0; if_flush = 0; if_addr = '0;
    lsu_req = 0; lsu_we = 0; lsu_be = '0; lsu_addr = '0; lsu_wdata = '0;
    bus_gnt = 0; bus_rvalid = 0; bus_err = 0; bus_rdata = '0;
  endtask

  task automatic test_reset();
    reset_n = 0;
    quiet();
    @(negedge clk);
    if_req = 1; lsu_req = 1; lsu_addr = 32'h44; bus_gnt = 1; bus_rvalid = 1;
    bus_rdata = 32'h1234;
    #1;
    n_cmp++;
    if ({bus_req, bus_we, bus_be, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, if_err, lsu_err, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_ctrl: got %b want all zero",
               {bus_req, bus_we, bus_be, if_gnt, lsu_gnt, if_rvalid, lsu_rvalid, if_err, lsu_err, busy});
    end
    n_cmp++;
    if (bus_addr !== 32'h0) begin
      n_bad++; $display("FAIL reset_addr: got %h want %h", bus_addr, 32'h0);
    end
    n_cmp++;
    if (if_rdata !== 32'h1234 || lsu_rdata !== 32'h1234) begin
      n_bad++; $display("FAIL reset_rdata: got %h/%h want %h", if_rdata, lsu_rdata, 32'h1234);
    end
    @(negedge clk);
    quiet();
    reset_n = 1;
  endtask

  task automatic test_if_read();
    @(negedge clk);
    quiet();
    if_req = 1; if_addr = 32'h100; bus_gnt = 1;
    #1;
    n_cmp++;
    if ({bus_req, bus_we, bus_be, if_gnt, lsu_gnt, busy} !== {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL if_read_gnt: got %b want %b", {bus_req, bus_we, bus_be, if_gnt, lsu_gnt, busy},
               {1'b1, 1'b0, 4'hF, 1'b1, 1'b0, 1'b0});
    end
    n_cmp++;
    if (bus_addr !== 32'h100 || bus_wdata !== 32'h0) begin
      n_bad++; $display("FAIL if_read_payload: got %h/%h want %h/%h", bus_addr, bus_wdata, 32'h100, 32'h0);
    end
    @(negedge clk);
    if_req = 0; bus_gnt = 0;
    #1;
    n_cmp++;
    if ({busy, bus_req, if_rvalid} !== 3'b100) begin
      n_bad++; $display("FAIL if_read_wait: got %b want %b", {busy, bus_req, if_rvalid}, 3'b100);
    end
    @(negedge clk);
    bus_rvalid = 1; bus_rdata = 32'h0000_0013;
    sb.push_back(mk(1, 0, 0, 0, 32'h0000_0013));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r || busy !== 1'b1) begin
      n_bad++; $display("FAIL if_read_rsp: got %h busy=%b want %h busy=1", obs_r, busy, exp_r);
    end
    @(negedge clk);
    bus_rvalid = 0;
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL if_read_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_contention();
    @(negedge clk);
    quiet();
    if_req = 1; if_addr = 32'h200; lsu_req = 1; lsu_addr = 32'h300; lsu_be = 4'hF;
    for (int unsigned c = 0; c < 4; c++) begin
      if (c > 0) begin
        @(negedge clk);
        lsu_addr = 32'h999 + c;
      end
      bus_gnt = (c == 3);
      #1;
      n_cmp++;
      if (bus_req !== 1'b1 || bus_addr !== 32'h300) begin
        n_bad++; $display("FAIL contention_addr c%0d: got req=%b %h want req=1 %h", c, bus_req, bus_addr, 32'h300);
      end
      n_cmp++;
      if ({lsu_gnt, if_gnt} !== {(c == 3), 1'b0}) begin
        n_bad++; $display("FAIL contention_gnt c%0d: got %b want %b", c, {lsu_gnt, if_gnt}, {(c == 3), 1'b0});
      end
    end
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_rdata = 32'hA5A5_A5A5;
    sb.push_back(mk(0, 0, 1, 0, 32'hA5A5_A5A5));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r || lsu_rdata !== 32'hA5A5_A5A5) begin
      n_bad++; $display("FAIL contention_rsp: got %h want %h", obs_r, exp_r);
    end
    @(negedge clk);
    bus_rvalid = 0;
  endtask

  task automatic test_starve();
    int unsigned st;
    logic        want_if;
    logic [31:0] want_addr;
    @(negedge clk);
    quiet();
    if_req = 1; if_addr = 32'h2000; bus_gnt = 1;
    #1;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL starve_clear_gnt: got %b want 1", if_gnt);
    end
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_rdata = 32'h55;
    sb.push_back(mk(1, 0, 0, 0, 32'h55));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL starve_clear_rsp: got %h want %h", obs_r, exp_r);
    end
    st = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      quiet();
      if_req = 1; if_addr = 32'h2000; lsu_req = 1; lsu_be = 4'hF;
      lsu_addr = 32'h1000 + 32'(k); bus_gnt = 1;
      want_if = (st == 4);
      want_addr = want_if ? 32'h2000 : 32'h1000 + 32'(k);
      if (want_if) st = 0;
      else if (st < 4) st++;
      #1;
      n_cmp++;
      if ({if_gnt, lsu_gnt} !== {want_if, ~want_if} || bus_addr !== want_addr) begin
        n_bad++;
        $display("FAIL starve_arb k%0d: got gnt if/lsu=%b %h want %b %h", k, {if_gnt, lsu_gnt}, bus_addr,
                 {want_if, ~want_if}, want_addr);
      end
      @(negedge clk);
      bus_gnt = 0; bus_rvalid = 1; bus_rdata = 32'(k);
      sb.push_back(mk(want_if, 0, ~want_if, 0, 32'(k)));
      #1;
      exp_r = sb.pop_front(); obs_r = observe();
      n_cmp++;
      if (obs_r !== exp_r) begin
        n_bad++; $display("FAIL starve_rsp k%0d: got %h want %h", k, obs_r, exp_r);
      end
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_store();
    @(negedge clk);
    quiet();
    lsu_req = 1; lsu_we = 1; lsu_be = 4'b0011; lsu_addr = 32'h8000_0004;
    lsu_wdata = 32'hDEAD_BEEF; bus_gnt = 1;
    #1;
    n_cmp++;
    if ({bus_req, bus_we, bus_be, lsu_gnt, if_gnt} !== {1'b1, 1'b1, 4'b0011, 1'b1, 1'b0}) begin
      n_bad++;
      $display("FAIL store_ctrl: got %b want %b", {bus_req, bus_we, bus_be, lsu_gnt, if_gnt},
               {1'b1, 1'b1, 4'b0011, 1'b1, 1'b0});
    end
    n_cmp++;
    if (bus_addr !== 32'h8000_0004 || bus_wdata !== 32'hDEAD_BEEF) begin
      n_bad++;
      $display("FAIL store_payload: got %h/%h want %h/%h", bus_addr, bus_wdata, 32'h8000_0004, 32'hDEAD_BEEF);
    end
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_err = 1;
    sb.push_back(mk(0, 0, 1, 1, 32'h0));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL store_rsp: got %h want %h", obs_r, exp_r);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_flush();
    // flush in IDLE: fetch ignored, LSU still served
    @(negedge clk);
    quiet();
    if_req = 1; if_flush = 1; if_addr = 32'h500;
    #1;
    n_cmp++;
    if (bus_req !== 1'b0 || if_gnt !== 1'b0) begin
      n_bad++; $display("FAIL flush_idle_if: got req=%b gnt=%b want 0/0", bus_req, if_gnt);
    end
    @(negedge clk);
    lsu_req = 1; lsu_addr = 32'h44; lsu_be = 4'hF; bus_gnt = 1;
    #1;
    n_cmp++;
    if (lsu_gnt !== 1'b1 || if_gnt !== 1'b0 || bus_addr !== 32'h44) begin
      n_bad++; $display("FAIL flush_idle_lsu: got gnt=%b%b %h want 10 %h", lsu_gnt, if_gnt, bus_addr, 32'h44);
    end
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_rdata = 32'h44;
    sb.push_back(mk(0, 0, 1, 0, 32'h44));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL flush_idle_rsp: got %h want %h", obs_r, exp_r);
    end
    // flush in WAIT_RSP, error response discarded
    @(negedge clk);
    quiet();
    if_req = 1; if_addr = 32'h600; bus_gnt = 1;
    #1;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL flush_rsp_gnt: got %b want 1", if_gnt);
    end
    @(negedge clk);
    quiet();
    if_flush = 1;
    #1;
    n_cmp++;
    if (busy !== 1'b1 || if_rvalid !== 1'b0) begin
      n_bad++; $display("FAIL flush_rsp_wait: got busy=%b rv=%b want 1/0", busy, if_rvalid);
    end
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_err = 1; bus_rdata = 32'hBAD;
    sb.push_back(mk(0, 0, 0, 0, 32'hBAD));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL flush_rsp_drop: got %h want %h", obs_r, exp_r);
    end
    @(negedge clk);
    quiet();
    #1;
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++; $display("FAIL flush_rsp_idle: got busy=%b want 0", busy);
    end
    // flush coincident with response
    @(negedge clk);
    if_req = 1; if_addr = 32'h700; bus_gnt = 1;
    @(negedge clk);
    quiet();
    if_flush = 1; bus_rvalid = 1; bus_rdata = 32'h77;
    sb.push_back(mk(0, 0, 0, 0, 32'h77));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL flush_same_cycle: got %h want %h", obs_r, exp_r);
    end
    // flush in WAIT_GNT: request held, grant reported, response dropped
    @(negedge clk);
    quiet();
    if_req = 1; if_addr = 32'h800;
    @(negedge clk);
    if_req = 0; if_flush = 1; if_addr = 32'h0;
    #1;
    n_cmp++;
    if (bus_req !== 1'b1 || bus_addr !== 32'h800) begin
      n_bad++; $display("FAIL flush_gnt_hold: got req=%b %h want 1 %h", bus_req, bus_addr, 32'h800);
    end
    @(negedge clk);
    if_flush = 0; bus_gnt = 1;
    #1;
    n_cmp++;
    if (if_gnt !== 1'b1) begin
      n_bad++; $display("FAIL flush_gnt_late: got %b want 1", if_gnt);
    end
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_rdata = 32'h66;
    sb.push_back(mk(0, 0, 0, 0, 32'h66));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL flush_gnt_drop: got %h want %h", obs_r, exp_r);
    end
    // discard flag must be clear for the next fetch
    @(negedge clk);
    quiet();
    if_req = 1; if_addr = 32'h900; bus_gnt = 1;
    @(negedge clk);
    quiet();
    bus_rvalid = 1; bus_rdata = 32'h88;
    sb.push_back(mk(1, 0, 0, 0, 32'h88));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r) begin
      n_bad++; $display("FAIL flush_recover: got %h want %h", obs_r, exp_r);
    end
    @(negedge clk);
    quiet();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    quiet();
    lsu_req = 1; lsu_addr = 32'h10; lsu_be = 4'hF; bus_gnt = 1;
    @(negedge clk);
    quiet();
    #1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy);
    end
    reset_n = 0;
    lsu_req = 1; bus_gnt = 1;
    #1;
    n_cmp++;
    if ({busy, bus_req, lsu_gnt, if_gnt} !== 4'b0000) begin
      n_bad++; $display("FAIL rstmid_abandon: got %b want 0000", {busy, bus_req, lsu_gnt, if_gnt});
    end
    @(negedge clk);
    quiet();
    reset_n = 1;
    @(negedge clk);
    bus_rvalid = 1; bus_err = 1; bus_rdata = 32'hFF;
    sb.push_back(mk(0, 0, 0, 0, 32'hFF));
    #1;
    exp_r = sb.pop_front(); obs_r = observe();
    n_cmp++;
    if (obs_r !== exp_r || busy !== 1'b0) begin
      n_bad++; $display("FAIL rstmid_late_rsp: got %h busy=%b want %h busy=0", obs_r, busy, exp_r);
    end
    @(negedge clk);
    quiet();
  endtask

  initial begin
    test_reset();
    test_if_read();
    test_contention();
    test_starve();
    test_store();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, range 1..7: consecutive IF-losing arbitration cycles before IF is forced to win.
REQ-002 clk  input  1  core clock, all state on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 if_req / if_addr  input  1/32  fetch read request and word address.
REQ-005 if_flush  input  1  pipeline flush of the fetch stage; discards fetch in flight.
REQ-006 if_gnt / if_rvalid / if_err  output  1/1/1  fetch accept, read data valid, access fault.
REQ-007 if_rdata  output  32  fetch read data.
REQ-008 lsu_req / lsu_we  input  1/1  LSU request and write enable.
REQ-009 lsu_be / lsu_addr / lsu_wdata  input  4/32/32  byte enables, address, write data.
REQ-010 lsu_gnt / lsu_rvalid / lsu_err  output  1/1/1  LSU accept, response valid (reads and writes), access fault.
REQ-011 lsu_rdata  output  32  LSU read data.
REQ-012 bus_req / bus_we  output  1/1  shared memory port request and write enable.
REQ-013 bus_be / bus_addr / bus_wdata  output  4/32/32  shared port payload; bus_be=4'hF, bus_wdata=0 for fetch.
REQ-014 bus_gnt / bus_rvalid / bus_err  input  1/1/1  port accept, response valid, error (qualified by bus_rvalid).
REQ-015 bus_rdata  input  32  port read data.
REQ-016 busy  output  1  high whenever state is not IDLE.

Function
REQ-017 The block SHALL implement FSM states IDLE, WAIT_GNT, WAIT_RSP with at most one outstanding bus transaction.
REQ-018 IDLE: if any request, select owner, drive bus_req=1 with owner payload combinationally; bus_gnt same cycle -> WAIT_RSP, else -> WAIT_GNT with owner and payload registered.
REQ-019 Selection: LSU wins when both request, unless starve counter == STARVE_LIMIT, then IF wins.
REQ-020 Starve counter (3 bits) SHALL increment, saturating at STARVE_LIMIT, on each cycle LSU is selected while if_req=1; clear on IF grant.
REQ-021 WAIT_GNT: bus_req held 1 with registered payload and owner; no re-arbitration; owner's requester payload changes ignored.
REQ-022 if_gnt/lsu_gnt SHALL equal bus_gnt gated by owner, asserted the cycle bus_gnt is sampled high with bus_req=1.
REQ-023 WAIT_RSP: bus_req=0; on bus_rvalid route rdata/err to owner's rvalid/rdata/err for exactly that cycle, return to IDLE; new request issued no earlier than next cycle.
REQ-024 Response latency: owner rvalid SHALL be combinational from bus_rvalid (zero added cycles).
REQ-025 if_flush in WAIT_RSP with IF owner: set discard flag; matching bus_rvalid SHALL NOT assert if_rvalid/if_err; flag clears on that response.
REQ-026 if_flush in IDLE: if_req ignored that cycle (LSU may still win).
REQ-027 if_flush in WAIT_GNT with IF owner: bus_req SHALL stay high until granted, then response discarded per REQ-025 (no bus protocol violation).
REQ-028 if_flush and bus_rvalid in same cycle with IF owner: response discarded.
REQ-029 bus_rvalid outside WAIT_RSP SHALL be ignored.
REQ-030 Non-owner gnt/rvalid/err SHALL be 0 at all times; rdata outputs SHALL be bus_rdata regardless.

Reset
REQ-031 On reset_n low: state IDLE, owner LSU, discard flag 0, starve counter 0, all payload registers 0.
REQ-032 During reset all outputs SHALL be 0 except if_rdata/lsu_rdata which follow bus_rdata.
REQ-033 Reset mid-transaction SHALL abandon it; a late bus_rvalid after release is ignored per REQ-029.

Verification
REQ-034 IF-only read, bus_gnt immediate, bus_rvalid 2 cycles later with rdata 0x00000013 -> if_gnt cycle 0, if_rvalid+if_rdata=0x00000013 cycle 2, busy cycles 0-2 only in WAIT_RSP.
REQ-035 Both request, bus_gnt low 3 cycles -> bus_addr stays lsu_addr, lsu_gnt on 4th cycle, if_gnt never.
REQ-036 LSU requests continuously with IF pending, STARVE_LIMIT=4 -> LSU wins first 4 arbitrations, IF wins 5th, counter back to 0.
REQ-037 IF granted, if_flush next cycle, bus_rvalid with bus_err=1 -> if_rvalid=0, if_err=0, state IDLE next cycle.
REQ-038 LSU store lsu_be=4'b0011, addr 0x80000004, data 0xDEADBEEF -> bus_we=1, bus_be=4'b0011, payload matches; bus_rvalid with bus_err=1 -> lsu_rvalid=1, lsu_err=1.
REQ-039 reset_n low in WAIT_RSP, released, spurious bus_rvalid -> no rvalid/err on either requester, state IDLE.
